uart_tx_fifo: RTL

- Serial UART transmitter: 8N1 framing, LSB first, idle-high line.
- Pairs with the team's UART receiver, which uses the same CLKS_PER_BIT convention: CLKS_PER_BIT = clock frequency / baud rate (e.g. 25 MHz / 115200 = 217).
- A small FIFO buffers bytes written over a valid/ready handshake. The transmit FSM sends queued bytes back-to-back, with no idle gap between frames.

---
 rtl/uart_tx_fifo.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter with 8N1 framing (LSB first, idle-high line). A small
//   FIFO buffers bytes written over a valid/ready handshake. The transmit FSM
//   sends queued bytes back-to-back with no idle gap between frames.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (clock frequency / baud), 2..65535
//   FIFO_DEPTH    byte entries in the FIFO, power of two, minimum 2
//
// Ports
//   Clock          system clock, rising edge
//   Reset_n        asynchronous active-low reset
//   Tx_Data        byte to enqueue, sampled only on an accept edge
//   Tx_Valid       Tx_Data is valid this cycle
//   Tx_Ready       FIFO can accept a byte (count != FIFO_DEPTH)
//   Output_Serial  registered UART line
//   Tx_Busy        FSM is not IDLE
//   Tx_Done        one-cycle pulse on the final cycle of each stop bit
//   Fifo_Count     queued bytes, excluding the byte in flight
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        Clock,
    input  logic                        Reset_n,
    input  logic [7:0]                  Tx_Data,
    input  logic                        Tx_Valid,
    output logic                        Tx_Ready,
    output logic                        Output_Serial,
    output logic                        Tx_Busy,
    output logic                        Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0] Fifo_Count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   LVL_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   LVL_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BIT  = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_level;
    logic             fifo_seen;
    logic             push;
    logic             pop;
    logic             has_data;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] clk_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       bit_idx;
    logic [2:0]       idx_nxt;
    logic [7:0]       shift;
    logic [7:0]       shift_nxt;
    logic             serial;
    logic             serial_nxt;
    logic             bit_end;

    assign Tx_Ready   = (fifo_level != LVL_FULL);
    assign push       = Tx_Valid && Tx_Ready;
    // The FSM sees the FIFO through a one-cycle registered occupancy flag, so
    // a byte pushed into an empty FIFO is popped two edges after acceptance.
    // The level term keeps a stale flag from ever popping an empty FIFO.
    assign has_data   = fifo_seen && (fifo_level != '0);
    assign Fifo_Count = fifo_level;

    // ---- FIFO storage and pointers ----
    always_ff @(posedge Clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= Tx_Data;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            fifo_seen  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + LVL_ONE;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - LVL_ONE;
            end
            fifo_seen <= (fifo_level != '0);
        end
    end

    // ---- Transmit FSM: next state ----
    assign bit_end = (clk_cnt == CNT_LAST);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = clk_cnt;
        idx_nxt    = bit_idx;
        pop        = 1'b0;
        shift_nxt  = shift;
        serial_nxt = 1'b1;

        case (state)
            IDLE: begin
                if (has_data) begin
                    pop       = 1'b1;
                    state_nxt = START_BIT;
                    cnt_nxt   = '0;
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    state_nxt = DATA_BIT;
                    cnt_nxt   = '0;
                    idx_nxt   = 3'd0;
                end else begin
                    cnt_nxt = clk_cnt + CNT_ONE;
                end
            end
            DATA_BIT: begin
                if (bit_end) begin
                    cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP_BIT;
                    end else begin
                        idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = clk_cnt + CNT_ONE;
                end
            end
            STOP_BIT: begin
                if (bit_end) begin
                    cnt_nxt = '0;
                    if (has_data) begin
                        pop       = 1'b1;
                        state_nxt = START_BIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = clk_cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (pop) begin
            shift_nxt = fifo_mem[rd_ptr];
        end

        // The line register is loaded from the next state so it changes on
        // the same edge as the FSM and never glitches.
        case (state_nxt)
            START_BIT: serial_nxt = 1'b0;
            DATA_BIT:  serial_nxt = shift_nxt[idx_nxt];
            default:   serial_nxt = 1'b1;
        endcase
    end

    // ---- Transmit FSM: registers ----
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            serial  <= 1'b1;
        end else begin
            state   <= state_nxt;
            clk_cnt <= cnt_nxt;
            bit_idx <= idx_nxt;
            serial  <= serial_nxt;
        end
    end

    always_ff @(posedge Clock) begin
        shift <= shift_nxt;
    end

    assign Output_Serial = serial;
    assign Tx_Busy       = (state != IDLE);
    assign Tx_Done       = (state == STOP_BIT) && bit_end;

endmodule
